// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and stall statistics.
// Flush and stall both turn the captured instruction into a bubble.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            ID_rs,
  input  logic [4:0]            ID_rt,
  input  logic [4:0]            ID_rd,
  input  logic [DATA_WIDTH-1:0] ID_read_data1,
  input  logic [DATA_WIDTH-1:0] ID_read_data2,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_valid,
  input  logic                  flush,
  output logic [4:0]            ID_EX_rs,
  output logic [4:0]            ID_EX_rt,
  output logic [4:0]            ID_EX_rd,
  output logic [DATA_WIDTH-1:0] ID_EX_read_data1,
  output logic [DATA_WIDTH-1:0] ID_EX_read_data2,
  output logic                  ID_EX_RegWrite,
  output logic                  ID_EX_MemRead,
  output logic                  ID_EX_valid,
  output logic                  stall,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  logic [4:0]            rs_q, rs_d;
  logic [4:0]            rt_q, rt_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] d1_q, d1_d;
  logic [DATA_WIDTH-1:0] d2_q, d2_d;
  logic                  rw_q, rw_d;
  logic                  mr_q, mr_d;
  logic                  v_q, v_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic hz;
  logic bubble;

  // r0 is hardwired zero, so a load into it can never create a dependency
  assign hz = v_q & mr_q & (rd_q != 5'd0) & ID_valid
            & ((rd_q == ID_rs) | (rd_q == ID_rt));

  assign stall  = hz & ~flush;
  assign bubble = flush | stall;

  always_comb begin
    rs_d = ID_rs;
    rt_d = ID_rt;
    rd_d = ID_rd;
    d1_d = ID_read_data1;
    d2_d = ID_read_data2;
    rw_d = ID_RegWrite & ID_valid;
    mr_d = ID_MemRead & ID_valid;
    v_d  = ID_valid;
    if (bubble) begin
      rs_d = '0;
      rt_d = '0;
      rd_d = '0;
      d1_d = '0;
      d2_d = '0;
      rw_d = 1'b0;
      mr_d = 1'b0;
      v_d  = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q  <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
      rw_q  <= 1'b0;
      mr_q  <= 1'b0;
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      rs_q  <= rs_d;
      rt_q  <= rt_d;
      rd_q  <= rd_d;
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      rw_q  <= rw_d;
      mr_q  <= mr_d;
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  assign ID_EX_rs         = rs_q;
  assign ID_EX_rt         = rt_q;
  assign ID_EX_rd         = rd_q;
  assign ID_EX_read_data1 = d1_q;
  assign ID_EX_read_data2 = d2_q;
  assign ID_EX_RegWrite   = rw_q;
  assign ID_EX_MemRead    = mr_q;
  assign ID_EX_valid      = v_q;
  assign stall_count      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use stall, flush,
// r0, valid gating, counter saturation and asynchronous reset.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    ID_rs, ID_rt, ID_rd;
  logic [DW-1:0] ID_read_data1, ID_read_data2;
  logic          ID_RegWrite, ID_MemRead, ID_valid, flush;
  logic [4:0]    ID_EX_rs, ID_EX_rt, ID_EX_rd;
  logic [DW-1:0] ID_EX_read_data1, ID_EX_read_data2;
  logic          ID_EX_RegWrite, ID_EX_MemRead, ID_EX_valid;
  logic          stall;
  logic [CW-1:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .ID_rs            (ID_rs),
    .ID_rt            (ID_rt),
    .ID_rd            (ID_rd),
    .ID_read_data1    (ID_read_data1),
    .ID_read_data2    (ID_read_data2),
    .ID_RegWrite      (ID_RegWrite),
    .ID_MemRead       (ID_MemRead),
    .ID_valid         (ID_valid),
    .flush            (flush),
    .ID_EX_rs         (ID_EX_rs),
    .ID_EX_rt         (ID_EX_rt),
    .ID_EX_rd         (ID_EX_rd),
    .ID_EX_read_data1 (ID_EX_read_data1),
    .ID_EX_read_data2 (ID_EX_read_data2),
    .ID_EX_RegWrite   (ID_EX_RegWrite),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_valid      (ID_EX_valid),
    .stall            (stall),
    .stall_count      (stall_count)
  );

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic rw,
                       input logic mr, input logic v, input logic fl);
    ID_rs = rs; ID_rt = rt; ID_rd = rd;
    ID_read_data1 = a; ID_read_data2 = b;
    ID_RegWrite = rw; ID_MemRead = mr; ID_valid = v; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(5'd0, 5'd0, 5'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_cmp++;
    if ({ID_EX_rs, ID_EX_rt, ID_EX_rd} !== 15'd0 ||
        ID_EX_read_data1 !== '0 || ID_EX_read_data2 !== '0 ||
        {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_valid} !== 3'b000) begin
      $display("FAIL reset_outputs: rs=%0d rt=%0d rd=%0d v=%b want all 0",
               ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_valid);
      n_bad++;
    end
    n_cmp++;
    if (stall !== 1'b0 || stall_count !== 4'd0) begin
      $display("FAIL reset_stall: stall=%b cnt=%0d want 0/0",
               stall, stall_count);
      n_bad++;
    end
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_capture();
    drive(5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      $display("FAIL capture_stall: got %b want 0", stall);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (ID_EX_rs !== 5'd3 || ID_EX_rt !== 5'd4 || ID_EX_rd !== 5'd5 ||
        ID_EX_read_data1 !== 32'h11 || ID_EX_read_data2 !== 32'h22) begin
      $display("FAIL capture_fields: rs=%0d rt=%0d rd=%0d d1=%h d2=%h want 3/4/5/11/22",
               ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_read_data1, ID_EX_read_data2);
      n_bad++;
    end
    n_cmp++;
    if ({ID_EX_RegWrite, ID_EX_MemRead, ID_EX_valid} !== 3'b101) begin
      $display("FAIL capture_ctrl: got %b want 101",
               {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_valid});
      n_bad++;
    end
  endtask

  task automatic test_load_use();
    drive(5'd1, 5'd2, 5'd8, 32'hA, 32'hB, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(5'd8, 5'd3, 5'd10, 32'h55, 32'h66, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      $display("FAIL loaduse_stall: got %b want 1", stall);
      n_bad++;
    end
    tick();
    exp_cnt++;
    n_cmp++;
    if (ID_EX_valid !== 1'b0 || ID_EX_MemRead !== 1'b0 ||
        ID_EX_rd !== 5'd0 || ID_EX_read_data1 !== '0) begin
      $display("FAIL loaduse_bubble: v=%b mr=%b rd=%0d d1=%h want 0/0/0/0",
               ID_EX_valid, ID_EX_MemRead, ID_EX_rd, ID_EX_read_data1);
      n_bad++;
    end
    n_cmp++;
    if (stall !== 1'b0 || stall_count !== 4'(exp_cnt)) begin
      $display("FAIL loaduse_once: stall=%b cnt=%0d want 0/%0d",
               stall, stall_count, exp_cnt);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (ID_EX_rs !== 5'd8 || ID_EX_rd !== 5'd10 || ID_EX_valid !== 1'b1 ||
        ID_EX_read_data2 !== 32'h66) begin
      $display("FAIL loaduse_held: rs=%0d rd=%0d v=%b d2=%h want 8/10/1/66",
               ID_EX_rs, ID_EX_rd, ID_EX_valid, ID_EX_read_data2);
      n_bad++;
    end
  endtask

  task automatic test_rt_r0();
    drive(5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(5'd4, 5'd9, 5'd11, 32'h3, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      $display("FAIL rt_match: got %b want 1", stall);
      n_bad++;
    end
    tick();
    exp_cnt++;
    tick();
    drive(5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(5'd0, 5'd0, 5'd12, 32'h3, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (stall !== 1'b0 || ID_EX_MemRead !== 1'b1) begin
      $display("FAIL r0_nohaz: stall=%b mr=%b want 0/1", stall, ID_EX_MemRead);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (ID_EX_rd !== 5'd12 || stall_count !== 4'(exp_cnt)) begin
      $display("FAIL r0_capture: rd=%0d cnt=%0d want 12/%0d",
               ID_EX_rd, stall_count, exp_cnt);
      n_bad++;
    end
  endtask

  task automatic test_flush();
    drive(5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(5'd7, 5'd3, 5'd13, 32'h9, 32'h8, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      $display("FAIL flush_stall: got %b want 0", stall);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (ID_EX_valid !== 1'b0 || ID_EX_rs !== 5'd0 || ID_EX_RegWrite !== 1'b0 ||
        stall_count !== 4'(exp_cnt)) begin
      $display("FAIL flush_bubble: v=%b rs=%0d rw=%b cnt=%0d want 0/0/0/%0d",
               ID_EX_valid, ID_EX_rs, ID_EX_RegWrite, stall_count, exp_cnt);
      n_bad++;
    end
  endtask

  task automatic test_invalid();
    drive(5'd6, 5'd14, 5'd15, 32'h77, 32'h88, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (ID_EX_rs !== 5'd6 || ID_EX_rd !== 5'd15 ||
        ID_EX_read_data1 !== 32'h77 ||
        {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_valid} !== 3'b000) begin
      $display("FAIL invalid_gate: rs=%0d rd=%0d d1=%h ctrl=%b want 6/15/77/000",
               ID_EX_rs, ID_EX_rd, ID_EX_read_data1,
               {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_valid});
      n_bad++;
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      drive(5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      drive(5'd8, 5'd8, 5'd3, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      if (i == 13) begin
        n_cmp++;
        if (stall_count !== 4'd14) begin
          $display("FAIL sat_preload: got %0d want 14", stall_count);
          n_bad++;
        end
      end
    end
    n_cmp++;
    if (stall_count !== 4'd15) begin
      $display("FAIL sat_hold: got %0d want 15", stall_count);
      n_bad++;
    end
  endtask

  task automatic test_async_reset();
    drive(5'd21, 5'd22, 5'd23, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({ID_EX_rs, ID_EX_rt, ID_EX_rd} !== 15'd0 ||
        ID_EX_read_data1 !== '0 || ID_EX_read_data2 !== '0 ||
        {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_valid} !== 3'b000 ||
        stall_count !== 4'd0 || stall !== 1'b0) begin
      $display("FAIL async_reset: rs=%0d d1=%h v=%b cnt=%0d stall=%b want 0",
               ID_EX_rs, ID_EX_read_data1, ID_EX_valid, stall_count, stall);
      n_bad++;
    end
    drive(5'd23, 5'd2, 5'd24, 32'h5, 32'h6, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    tick();
    n_cmp++;
    if (ID_EX_rs !== 5'd23 || ID_EX_rd !== 5'd24 || ID_EX_valid !== 1'b1 ||
        stall_count !== 4'd0) begin
      $display("FAIL reset_release: rs=%0d rd=%0d v=%b cnt=%0d want 23/24/1/0",
               ID_EX_rs, ID_EX_rd, ID_EX_valid, stall_count);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_rt_r0();
    test_flush();
    test_invalid();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the operand data fields.
REQ-002 Parameter CNT_WIDTH, default 16, width of the stall statistics counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ID_rs  input  5  source register 1 of the instruction in decode.
REQ-006 ID_rt  input  5  source register 2 of the instruction in decode.
REQ-007 ID_rd  input  5  destination register of the instruction in decode.
REQ-008 ID_read_data1  input  DATA_WIDTH  register file value for ID_rs.
REQ-009 ID_read_data2  input  DATA_WIDTH  register file value for ID_rt.
REQ-010 ID_RegWrite  input  1  decoded RegWrite control.
REQ-011 ID_MemRead  input  1  decoded MemRead control (load).
REQ-012 ID_valid  input  1  decode stage holds a real instruction.
REQ-013 flush  input  1  squash the decode-stage instruction (taken branch/jump).
REQ-014 ID_EX_rs, ID_EX_rt, ID_EX_rd  output  5 each  registered register specifiers, consumed by the forwarding unit.
REQ-015 ID_EX_read_data1, ID_EX_read_data2  output  DATA_WIDTH each  registered operands.
REQ-016 ID_EX_RegWrite, ID_EX_MemRead, ID_EX_valid  output  1 each  registered controls.
REQ-017 stall  output  1  combinational; hold PC and IF/ID register this cycle.
REQ-018 stall_count  output  CNT_WIDTH  registered count of stall cycles.

Function
REQ-019 Load-use hazard (hz) is asserted when ID_EX_valid & ID_EX_MemRead & ID_EX_rd != 0 & ID_valid & (ID_EX_rd == ID_rs | ID_EX_rd == ID_rt).
REQ-020 stall is asserted when hz is asserted and flush is deasserted; otherwise stall is 0, with no latency (same cycle).
REQ-021 Each rising edge has three cases, in priority order: flush=1 -> bubble; stall=1 -> bubble; otherwise -> capture all ID_* inputs into the matching ID_EX_* outputs.
REQ-022 A bubble forces ID_EX_RegWrite=0, ID_EX_MemRead=0, ID_EX_valid=0, and zeroes rs/rt/rd and both data fields.
REQ-023 A stall lasts exactly one cycle per load: the inserted bubble clears ID_EX_MemRead, so hz deasserts on the next cycle while the held instruction is unchanged.
REQ-024 Capture with ID_valid=0 stores the fields as presented and sets ID_EX_valid=0; ID_EX_RegWrite and ID_EX_MemRead are gated by ID_valid (stored 0).
REQ-025 stall_count increments by 1 on each rising edge where stall=1, saturates at all-ones, and never wraps.
REQ-026 flush and hz asserted together: flush wins, stall=0, bubble inserted, stall_count unchanged.
REQ-027 Register 0 never causes a hazard, even when ID_EX_MemRead=1 and ID_rs=ID_rt=0.
REQ-028 Latency ID input -> ID_EX output is exactly one clock when no stall and no flush occur.

Reset
REQ-029 While reset=1, all ID_EX_* outputs and stall_count are 0, asynchronously and independent of clk.
REQ-030 stall is 0 during reset, because ID_EX_valid=0.
REQ-031 Reset deasserted mid-stall: the first edge after release performs a normal capture; no stale bubble or stall is kept.

Verification
REQ-032 Normal capture: ID_rs=3, ID_rt=4, ID_rd=5, data1=0x11, data2=0x22, RegWrite=1, valid=1 -> next edge ID_EX_* equal these values, stall=0.
REQ-033 Load-use: load with rd=8 (MemRead=1) captured, then decode rs=8 -> stall=1 for exactly one cycle, ID_EX_valid=0 after that edge, held instruction captured on the following edge, stall_count=1.
REQ-034 rt match and r0: load rd=9, decode rt=9 -> stall=1; load rd=0, decode rs=0 -> stall=0.
REQ-035 Flush priority: hz condition present and flush=1 -> stall=0, bubble inserted, stall_count unchanged.
REQ-036 Saturation: preload the counter to all-ones minus 1 (CNT_WIDTH=4, value 14), force two stalls -> stall_count reads 15 and stays 15.
REQ-037 Async reset: assert reset between edges while outputs are nonzero -> all outputs read 0 before the next clk edge.
